fetch_control: RTL and testbench

FETCH_CONTROL -- requirements
Module: fetch_control

---
 rtl/fetch_control_pkg.sv | 30 +++
 rtl/fetch_timer.sv | 38 +++
 rtl/fetch_control.sv | 166 ++++++++++++++++
 tb/tb_fetch_control.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_control_pkg.sv
// -----------------------------------------------------------------------------
// fetch_control_pkg
// Shared definitions for the fetch/decode/execute sequencer:
//   - state encoding (legacy-compatible localparam constants)
//   - opcode values recognised by DECODE
//   - position of the opcode field inside the instruction word
// -----------------------------------------------------------------------------
package fetch_control_pkg;

    // Sequencer state encoding. ST_ERROR is only ever entered when the
    // fetch timeout (FETCH_TIMEOUT_EN) is compiled in.
    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_FETCH  = 3'd1;
    localparam state_t ST_DECODE = 3'd2;
    localparam state_t ST_EXEC   = 3'd3;
    localparam state_t ST_UPDATE = 3'd4;
    localparam state_t ST_HALT   = 3'd5;
    localparam state_t ST_ERROR  = 3'd6;

    // Opcode field: instr[15:12].
    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 12;

    localparam logic [3:0] OP_HALT = 4'hF;
    localparam logic [3:0] OP_JMP  = 4'hE;
    localparam logic [3:0] OP_BZ   = 4'hD;

endpackage : fetch_control_pkg

// File: rtl/fetch_timer.sv
// -----------------------------------------------------------------------------
// fetch_timer
// Counts FETCH cycles spent waiting for a memory acknowledge.
//   clock    in  system clock, rising edge
//   reset    in  synchronous, active-high
//   clear    in  force the count to zero (held while not fetching)
//   count    in  advance the count by one this cycle
//   expired  out current cycle is the last one allowed (count == TIMEOUT_CYCLES-1)
// -----------------------------------------------------------------------------
module fetch_timer
    import fetch_control_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic count,
    output logic expired
);

    // The count never needs to exceed TIMEOUT_CYCLES-1: the sequencer
    // leaves FETCH on the cycle expired is seen.
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] count_q;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count_q <= '0;
        end else if (count) begin
            count_q <= count_q + CW'(1);
        end
    end

    assign expired = (count_q == CW'(TIMEOUT_CYCLES - 1));

endmodule : fetch_timer

// File: rtl/fetch_control.sv
// -----------------------------------------------------------------------------
// fetch_control
// Instruction sequencer: IDLE -> FETCH -> DECODE -> (EXEC) -> UPDATE -> FETCH.
// HALT is terminal until reset. With the macro FETCH_TIMEOUT_EN defined, a
// FETCH that waits TIMEOUT_CYCLES cycles without mem_ack moves to ERROR.
//
// Ports:
//   clock       in   system clock, rising edge
//   reset       in   synchronous, active-high
//   run         in   start request, sampled only in IDLE
//   mem_req     out  instruction read request
//   mem_ack     in   memory read-data-valid
//   mem_rdata   in   instruction word from memory
//   instr       out  instruction register
//   cond_flag   in   branch condition (zero flag)
//   exec_start  out  one-cycle datapath start pulse
//   exec_done   in   datapath operation complete
//   pc_enable   out  PC update strobe
//   pc_jump     out  PC relative-jump select (only with pc_enable)
//   halted      out  high in HALT
//   bus_error   out  high in ERROR (0 when FETCH_TIMEOUT_EN is undefined)
// -----------------------------------------------------------------------------
module fetch_control
    import fetch_control_pkg::*;
#(
    parameter int ADDR_MAX       = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                run,
    output logic                mem_req,
    input  logic                mem_ack,
    input  logic [ADDR_MAX-1:0] mem_rdata,
    output logic [ADDR_MAX-1:0] instr,
    input  logic                cond_flag,
    output logic                exec_start,
    input  logic                exec_done,
    output logic                pc_enable,
    output logic                pc_jump,
    output logic                halted,
    output logic                bus_error
);

    // Elaboration-time sanity checks on the configuration.
    if (ADDR_MAX < OPCODE_MSB + 1) begin : g_bad_width
        $error("fetch_control: ADDR_MAX must hold the opcode field");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("fetch_control: TIMEOUT_CYCLES must be at least 1");
    end

    state_t     state, state_next;
    logic       taken, taken_next;
    logic       exec_first, exec_first_next;
    logic       load_instr;
    logic [3:0] opcode;

    assign opcode = instr[OPCODE_MSB:OPCODE_LSB];

`ifdef FETCH_TIMEOUT_EN
    logic timer_expired;
    logic timer_clear;
    logic timer_count;

    // Held clear outside FETCH so every FETCH entry starts from zero.
    assign timer_clear = (state != ST_FETCH);
    assign timer_count = (state == ST_FETCH) && !mem_ack;

    fetch_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_fetch_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (timer_clear),
        .count   (timer_count),
        .expired (timer_expired)
    );

    assign bus_error = (state == ST_ERROR);
`else
    assign bus_error = 1'b0;
`endif

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can infer a latch.
        state_next      = state;
        taken_next      = taken;
        exec_first_next = 1'b0;
        load_instr      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (run) state_next = ST_FETCH;
            end
            ST_FETCH: begin
                // An ack on the final counted cycle wins over the timeout.
                if (mem_ack) begin
                    load_instr = 1'b1;
                    state_next = ST_DECODE;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (timer_expired) begin
                    state_next = ST_ERROR;
                end
`endif
            end
            ST_DECODE: begin
                case (opcode)
                    OP_HALT: state_next = ST_HALT;
                    OP_JMP: begin
                        taken_next = 1'b1;
                        state_next = ST_UPDATE;
                    end
                    OP_BZ: begin
                        taken_next = cond_flag;
                        state_next = ST_UPDATE;
                    end
                    default: begin
                        exec_first_next = 1'b1;
                        state_next      = ST_EXEC;
                    end
                endcase
            end
            ST_EXEC: begin
                // exec_done is ignored in the exec_start cycle.
                if (!exec_first && exec_done) begin
                    taken_next = 1'b0;
                    state_next = ST_UPDATE;
                end
            end
            ST_UPDATE: state_next = ST_FETCH;
            ST_HALT:   state_next = ST_HALT;
`ifdef FETCH_TIMEOUT_EN
            ST_ERROR:  state_next = ST_ERROR;
`endif
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every register samples the pre-edge values of the others.
        if (reset) begin
            state      <= ST_IDLE;
            instr      <= '0;
            taken      <= 1'b0;
            exec_first <= 1'b0;
        end else begin
            state      <= state_next;
            taken      <= taken_next;
            exec_first <= exec_first_next;
            if (load_instr) instr <= mem_rdata;
        end
    end

    // Moore outputs: each strobe belongs to exactly one state, which keeps
    // mem_req, exec_start and pc_enable mutually exclusive by construction.
    assign mem_req    = (state == ST_FETCH);
    assign exec_start = (state == ST_EXEC) && exec_first;
    assign pc_enable  = (state == ST_UPDATE);
    assign pc_jump    = (state == ST_UPDATE) && taken;
    assign halted     = (state == ST_HALT);

endmodule : fetch_control

// File: tb/tb_fetch_control.sv
// -----------------------------------------------------------------------------
// tb_fetch_control
// Directed bench for fetch_control. Each instruction pushes its expected
// outcome (jump select, exec pulses, FETCH-to-FETCH latency, halt) into a
// scoreboard queue when the memory acknowledge is driven; the entry is popped
// and compared once the sequencer reaches its next FETCH or HALT.
// Build with FETCH_TIMEOUT_EN defined to include the timeout steps.
// -----------------------------------------------------------------------------
module tb_fetch_control;

    localparam int ADDR_MAX       = 16;
    localparam int TIMEOUT_CYCLES = 4;

    logic                clock;
    logic                reset;
    logic                run;
    logic                mem_req;
    logic                mem_ack;
    logic [ADDR_MAX-1:0] mem_rdata;
    logic [ADDR_MAX-1:0] instr;
    logic                cond_flag;
    logic                exec_start;
    logic                exec_done;
    logic                pc_enable;
    logic                pc_jump;
    logic                halted;
    logic                bus_error;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic jump;
        int   n_exec;
        int   latency;
        logic halt;
    } exp_t;

    exp_t sb[$];

    fetch_control #(
        .ADDR_MAX       (ADDR_MAX),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .run        (run),
        .mem_req    (mem_req),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .instr      (instr),
        .cond_flag  (cond_flag),
        .exec_start (exec_start),
        .exec_done  (exec_done),
        .pc_enable  (pc_enable),
        .pc_jump    (pc_jump),
        .halted     (halted),
        .bus_error  (bus_error)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clock);
    endtask

    function automatic logic [5:0] outs();
        return {mem_req, exec_start, pc_enable, pc_jump, halted, bus_error};
    endfunction

    // Reset with every other input active to show reset wins.
    task automatic do_reset();
        reset     = 1'b1;
        run       = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 16'hFFFF;
        exec_done = 1'b1;
        cond_flag = 1'b1;
        step();
        step();
        check("reset outputs", 32'(outs()), 32'h0);
        check("reset instr", 32'(instr), 32'h0);
        reset     = 1'b0;
        run       = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 16'h0BAD;
        exec_done = 1'b0;
        cond_flag = 1'b0;
    endtask

    // From IDLE: request run, arrive at the first FETCH cycle.
    task automatic start();
        run = 1'b1;
        step();
        run = 1'b0;
        check("start mem_req", 32'(mem_req), 32'h1);
    endtask

    // Entered at the first FETCH cycle. ack_delay = FETCH cycles without ack
    // before the acked one; done_delay = cycles after exec_start at which
    // exec_done is raised; done_early also raises exec_done during exec_start.
    task automatic run_instr(input string tag, input logic [15:0] word,
                             input int ack_delay, input logic cf,
                             input int done_delay, input bit done_early);
        exp_t          e;
        logic [3:0]    op;
        logic [15:0]   prev;
        int            c;
        int            req_n;
        int            es_n;
        int            es_at;
        int            pe_n;
        logic          jump_seen;
        bit            overlap;
        bit            instr_moved;
        bit            err_seen;
        bit            reached;

        c = 0; req_n = 0; es_n = 0; es_at = 0; pe_n = 0;
        jump_seen = 1'b0; overlap = 1'b0; instr_moved = 1'b0;
        err_seen = 1'b0; reached = 1'b0;
        prev = instr;
        cond_flag = cf;

        for (int k = 0; k <= ack_delay; k++) begin
            if (mem_req) req_n++;
            if (bus_error) err_seen = 1'b1;
            if (instr !== prev) instr_moved = 1'b1;
            mem_ack   = (k == ack_delay);
            mem_rdata = (k == ack_delay) ? word : 16'h0BAD ^ 16'(k);
            step();
            c++;
        end
        mem_ack   = 1'b0;
        mem_rdata = 16'h0BAD;

        op        = word[15:12];
        e.halt    = (op == 4'hF);
        e.jump    = (op == 4'hE) || ((op == 4'hD) && cf);
        e.n_exec  = (op == 4'hF || op == 4'hE || op == 4'hD) ? 0 : 1;
        e.latency = e.halt ? ack_delay + 2
                           : ack_delay + 3 + (e.n_exec != 0 ? 1 + done_delay : 0);
        sb.push_back(e);

        check({tag, " mem_req cycles"}, 32'(req_n), 32'(ack_delay + 1));
        check({tag, " instr"}, 32'(instr), 32'(word));
        check({tag, " instr stable while waiting"}, 32'(instr_moved), 32'h0);

        for (int k = 0; k < 40; k++) begin
            if (int'(mem_req) + int'(exec_start) + int'(pc_enable) > 1) overlap = 1'b1;
            if (!pc_enable && pc_jump) overlap = 1'b1;
            if (bus_error) err_seen = 1'b1;
            if (exec_start) begin
                es_n++;
                es_at = c;
            end
            if (pc_enable) begin
                pe_n++;
                jump_seen = pc_jump;
            end
            if (halted || (mem_req && pe_n > 0)) begin
                reached = 1'b1;
                break;
            end
            exec_done = ((es_n > 0) && (c >= es_at + done_delay)) ||
                        (done_early && exec_start);
            step();
            c++;
        end
        exec_done = 1'b0;

        e = sb.pop_front();
        check({tag, " reached fetch/halt"}, 32'(reached), 32'h1);
        check({tag, " latency"}, 32'(c), 32'(e.latency));
        check({tag, " exec_start pulses"}, 32'(es_n), 32'(e.n_exec));
        check({tag, " pc_enable pulses"}, 32'(pe_n), e.halt ? 32'h0 : 32'h1);
        check({tag, " pc_jump"}, 32'(jump_seen), 32'(e.jump));
        check({tag, " halted"}, 32'(halted), 32'(e.halt));
        check({tag, " strobe exclusivity"}, 32'(overlap), 32'h0);
        check({tag, " bus_error"}, 32'(err_seen), 32'h0);
    endtask

    initial begin
        int  h;
        bit  bad;
        int  n;

        do_reset();
        start();

        // Back-to-back program; each call ends at the next FETCH.
        run_instr("op1234", 16'h1234, 0, 1'b0, 1, 1'b0);
        run_instr("jmp", 16'hE005, 0, 1'b0, 1, 1'b0);
        run_instr("bz0", 16'hD003, 0, 1'b0, 1, 1'b0);
        run_instr("bz1", 16'hD003, 0, 1'b1, 1, 1'b0);
        run_instr("wait3", 16'h1234, 3, 1'b0, 1, 1'b0);
        run_instr("early_done", 16'h2345, 0, 1'b0, 1, 1'b1);
        run_instr("slow_exec", 16'h3456, 1, 1'b1, 3, 1'b0);
`ifndef FETCH_TIMEOUT_EN
        run_instr("wait10", 16'h4567, 10, 1'b0, 1, 1'b0);
`endif
        run_instr("halt", 16'hF000, 0, 1'b1, 1, 1'b0);

        // HALT persists with run and other inputs active.
        run = 1'b1; mem_ack = 1'b1; exec_done = 1'b1;
        h = 0; bad = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (halted) h++;
            if (outs() !== 6'b000010) bad = 1'b1;
        end
        check("halt hold cycles", 32'(h), 32'd20);
        check("halt strobes quiet", 32'(bad), 32'h0);
        do_reset();
        step();
        step();
        check("idle after halt reset", 32'(outs()), 32'h0);

        // Reset in the middle of EXEC.
        start();
        mem_ack = 1'b1; mem_rdata = 16'h1234;
        step();
        mem_ack = 1'b0;
        step();
        check("midexec exec_start", 32'(exec_start), 32'h1);
        reset = 1'b1; run = 1'b1; exec_done = 1'b1; mem_ack = 1'b1;
        step();
        check("midexec reset outputs", 32'(outs()), 32'h0);
        check("midexec reset instr", 32'(instr), 32'h0);
        reset = 1'b0; run = 1'b0; exec_done = 1'b0; mem_ack = 1'b0;
        step();
        check("midexec idle", 32'(outs()), 32'h0);

        // Reset beats a same-cycle mem_ack in FETCH.
        start();
        mem_ack = 1'b1; mem_rdata = 16'hABCD; reset = 1'b1;
        step();
        check("midfetch reset instr", 32'(instr), 32'h0);
        check("midfetch reset outputs", 32'(outs()), 32'h0);
        reset = 1'b0; mem_ack = 1'b0;

`ifdef FETCH_TIMEOUT_EN
        // No ack: ERROR after TIMEOUT_CYCLES FETCH cycles.
        do_reset();
        start();
        n = 0;
        for (int k = 0; k < 10; k++) begin
            if (bus_error) break;
            if (mem_req) n++;
            step();
        end
        check("timeout fetch cycles", 32'(n), 32'(TIMEOUT_CYCLES));
        check("timeout bus_error", 32'(bus_error), 32'h1);
        check("timeout mem_req", 32'(mem_req), 32'h0);
        run = 1'b1; mem_ack = 1'b1;
        step();
        step();
        check("error holds", 32'(outs()), 32'h1);
        run = 1'b0; mem_ack = 1'b0;

        // Ack on the final counted cycle wins.
        do_reset();
        start();
        run_instr("ack_last", 16'hE001, TIMEOUT_CYCLES - 1, 1'b0, 1, 1'b0);
`else
        n = 0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_fetch_control
